// File: rtl/fib_job_sequencer.sv
// Fibonacci job sequencer: accepts an index range from the host and requests one
// engine computation per index over the start/i/done handshake. Each result is
// streamed out as (index, value) over valid/ready. Every engine request has a
// timeout guard.
module fib_job_sequencer #(
    parameter int IDX_W   = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    // host command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IDX_W-1:0]  cmd_first,
    input  logic [IDX_W-1:0]  cmd_last,
    // engine handshake
    output logic              fib_start,
    output logic [IDX_W-1:0]  fib_i,
    input  logic              fib_done,
    input  logic [DATA_W-1:0] fib_result,
    // result stream
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDX_W-1:0]  res_idx,
    output logic [DATA_W-1:0] res_data,
    output logic              res_last,
    // status
    output logic              busy,
    output logic              err_timeout,
    output logic              err_range
);

    // The timer only has to count 0..TIMEOUT-1.
    localparam int               TMR_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PUSH
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W-1:0]    r_cur;
    logic [IDX_W-1:0]    r_last;
    logic [TMR_W-1:0]    r_timer;
    logic [IDX_W-1:0]    r_res_idx;
    logic [DATA_W-1:0]   r_res_data;
    logic                r_res_last;
    logic                r_err_timeout;
    logic                r_err_range;

    logic                w_accept;
    logic                w_bad_range;
    logic                w_expired;
    logic                w_at_last;

    assign w_accept    = (r_state == S_IDLE) && cmd_valid;
    assign w_bad_range = cmd_first > cmd_last;
    assign w_expired   = (r_timer == TMR_MAX);
    // cur stops at last, so an all-ones last index never needs to wrap.
    assign w_at_last   = (r_cur == r_last);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: all clocked state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            r_state <= w_next;
        end
    end

    // Next-state decode; fib_done only matters while waiting on the engine.
    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && !w_bad_range) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (fib_done)       w_next = S_PUSH;   // done wins over expiry
                else if (w_expired) w_next = S_IDLE;
            end
            S_PUSH:  if (res_ready) w_next = w_at_last ? S_IDLE : S_ISSUE;
            default: w_next = S_IDLE;
        endcase
    end

    // Job registers, request timer, result capture and error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur         <= '0;
            r_last        <= '0;
            r_timer       <= '0;
            r_res_idx     <= '0;
            r_res_data    <= '0;
            r_res_last    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_range   <= 1'b0;
        end else begin
            r_err_range <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cur         <= cmd_first;
                        r_last        <= cmd_last;
                        r_err_timeout <= 1'b0;
                        r_err_range   <= w_bad_range;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                end
                S_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    if (fib_done) begin
                        r_res_data <= fib_result;
                        r_res_idx  <= r_cur;
                        r_res_last <= w_at_last;
                    end else if (w_expired) begin
                        r_err_timeout <= 1'b1;
                    end
                end
                S_PUSH: begin
                    if (res_ready && !w_at_last) r_cur <= r_cur + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign fib_start   = (r_state == S_ISSUE);
    assign fib_i       = r_cur;
    assign res_valid   = (r_state == S_PUSH);
    assign res_idx     = r_res_idx;
    assign res_data    = r_res_data;
    assign res_last    = r_res_last;
    assign busy        = (r_state != S_IDLE);
    assign err_timeout = r_err_timeout;
    assign err_range   = r_err_range;

endmodule

// File: tb/tb_fib_job_sequencer.sv
// Directed bench for fib_job_sequencer with a behavioural engine and a result monitor.
module tb_fib_job_sequencer;

    localparam int IDX_W   = 5;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [IDX_W-1:0]  cmd_first;
    logic [IDX_W-1:0]  cmd_last;
    logic              fib_start;
    logic [IDX_W-1:0]  fib_i;
    logic              fib_done;
    logic [DATA_W-1:0] fib_result;
    logic              res_valid;
    logic              res_ready;
    logic [IDX_W-1:0]  res_idx;
    logic [DATA_W-1:0] res_data;
    logic              res_last;
    logic              busy;
    logic              err_timeout;
    logic              err_range;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    bit eng_en = 1'b1;
    int eng_delay = 3;
    logic [IDX_W-1:0]  eng_idx;

    logic [IDX_W-1:0]  q_idx[$];
    logic [DATA_W-1:0] q_data[$];
    logic              q_last[$];

    fib_job_sequencer #(.IDX_W(IDX_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_first(cmd_first), .cmd_last(cmd_last),
        .fib_start(fib_start), .fib_i(fib_i),
        .fib_done(fib_done), .fib_result(fib_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_idx(res_idx), .res_data(res_data), .res_last(res_last),
        .busy(busy), .err_timeout(err_timeout), .err_range(err_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus source for the engine model only; expected values below are literals.
    function automatic logic [DATA_W-1:0] fib(input int n);
        logic [DATA_W-1:0] a, b, t;
        a = '0;
        b = 1;
        for (int k = 0; k < n; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Engine model: answers a start pulse eng_delay cycles later with a one-cycle done.
    initial begin
        fib_done   = 1'b0;
        fib_result = 32'hDEAD_BEEF;
        eng_idx    = '0;
        forever begin
            @(negedge clk);
            fib_done   = 1'b0;
            fib_result = 32'hDEAD_BEEF;
            if (fib_start && eng_en) begin
                eng_idx = fib_i;
                repeat (eng_delay) @(negedge clk);
                fib_done   = 1'b1;
                fib_result = fib(int'(eng_idx));
            end
        end
    end

    // Monitor: counts start pulses and records accepted results.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (fib_start === 1'b1) start_cnt++;
            if (res_valid === 1'b1 && res_ready === 1'b1) begin
                q_idx.push_back(res_idx);
                q_data.push_back(res_data);
                q_last.push_back(res_last);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        q_idx.delete();
        q_data.delete();
        q_last.delete();
    endtask

    // Returns on the negedge just after the accepting clock edge.
    task automatic send_cmd(input logic [IDX_W-1:0] f, input logic [IDX_W-1:0] l);
        int n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        cmd_first = f;
        cmd_last  = l;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL %s_idle: busy=%b after 500 cycles, required 0", name, busy);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_first = '0;
        cmd_last  = '0;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || fib_start !== 1'b0 || res_valid !== 1'b0) begin
            $display("FAIL reset_ctrl: cmd_ready=%b busy=%b fib_start=%b res_valid=%b, required 1 0 0 0",
                     cmd_ready, busy, fib_start, res_valid);
            errors++;
        end
        checks++;
        if (fib_i !== '0 || res_idx !== '0 || res_data !== '0 || res_last !== 1'b0 ||
            err_timeout !== 1'b0 || err_range !== 1'b0) begin
            $display("FAIL reset_data: fib_i=%0d res_idx=%0d res_data=%0d res_last=%b err_t=%b err_r=%b, required all 0",
                     fib_i, res_idx, res_data, res_last, err_timeout, err_range);
            errors++;
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int n = 0;
        int s0;
        eng_delay = 3;
        clear_q();
        s0 = start_cnt;
        send_cmd(5'd0, 5'd0);
        checks++;
        if (fib_start !== 1'b1 || fib_i !== 5'd0) begin
            $display("FAIL single_start: fib_start=%b fib_i=%0d one cycle after accept, required 1 0", fib_start, fib_i);
            errors++;
        end
        // done arrives 3 cycles after start, res_valid one cycle after done
        while (res_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 4) begin
            $display("FAIL single_latency: res_valid %0d cycles after fib_start, required 4", n);
            errors++;
        end
        wait_idle("single");
        checks++;
        if (q_idx.size() != 1 || q_idx[0] !== 5'd0 || q_data[0] !== 32'd0 || q_last[0] !== 1'b1 ||
            start_cnt - s0 != 1) begin
            $display("FAIL single_result: count=%0d idx=%0d data=%0d last=%b starts=%0d, required 1 0 0 1 1",
                     q_idx.size(), q_idx[0], q_data[0], q_last[0], start_cnt - s0);
            errors++;
        end
    endtask

    task automatic test_multi();
        logic [DATA_W-1:0] exp_data [5];
        int s0;
        exp_data = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5};
        clear_q();
        s0 = start_cnt;
        send_cmd(5'd1, 5'd5);
        wait_idle("multi");
        checks++;
        if (q_idx.size() != 5) begin
            $display("FAIL multi_count: results=%0d, required 5", q_idx.size());
            errors++;
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (q_idx[k] !== 5'(k + 1) || q_data[k] !== exp_data[k] || q_last[k] !== (k == 4)) begin
                    $display("FAIL multi_res%0d: idx=%0d data=%0d last=%b, required %0d %0d %b",
                             k, q_idx[k], q_data[k], q_last[k], k + 1, exp_data[k], (k == 4));
                    errors++;
                end
            end
        end
        checks++;
        if (start_cnt - s0 != 5) begin
            $display("FAIL multi_starts: fib_start pulses=%0d, required 5", start_cnt - s0);
            errors++;
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        bit held_ok = 1'b1;
        clear_q();
        res_ready = 1'b0;
        send_cmd(5'd10, 5'd10);
        while (res_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            $display("FAIL bp_valid: res_valid=%b after 100 cycles, required 1", res_valid);
            errors++;
        end
        repeat (20) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== 32'd55 || res_idx !== 5'd10 || res_last !== 1'b1)
                held_ok = 1'b0;
        end
        checks++;
        if (!held_ok) begin
            $display("FAIL bp_hold: valid=%b data=%0d idx=%0d last=%b, required 1 55 10 1 throughout",
                     res_valid, res_data, res_idx, res_last);
            errors++;
        end
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || q_data.size() != 1) begin
            $display("FAIL bp_release: busy=%b res_valid=%b results=%0d, required 0 0 1",
                     busy, res_valid, q_data.size());
            errors++;
        end
    endtask

    task automatic test_max_index();
        int s0;
        clear_q();
        s0 = start_cnt;
        send_cmd(5'd30, 5'd31);
        wait_idle("maxidx");
        checks++;
        if (q_idx.size() != 2 || q_idx[0] !== 5'd30 || q_data[0] !== 32'd832040 || q_last[0] !== 1'b0 ||
            q_idx[1] !== 5'd31 || q_data[1] !== 32'd1346269 || q_last[1] !== 1'b1 || start_cnt - s0 != 2) begin
            $display("FAIL maxidx_results: count=%0d starts=%0d first=(%0d,%0d,%b), required 2 2 (30,832040,0) then (31,1346269,1)",
                     q_idx.size(), start_cnt - s0, q_idx[0], q_data[0], q_last[0]);
            errors++;
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        eng_en = 1'b0;
        clear_q();
        send_cmd(5'd4, 5'd6);
        // WAIT spans TIMEOUT cycles (timer 0..TIMEOUT-1); the flag registers on the last one.
        while (err_timeout !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != TIMEOUT + 1) begin
            $display("FAIL timeout_latency: err_timeout after %0d cycles from fib_start, required %0d", n, TIMEOUT + 1);
            errors++;
        end
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            $display("FAIL timeout_idle: busy=%b cmd_ready=%b, required 0 1", busy, cmd_ready);
            errors++;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (err_timeout !== 1'b1 || q_idx.size() != 0) begin
            $display("FAIL timeout_sticky: err_timeout=%b results=%0d, required 1 0", err_timeout, q_idx.size());
            errors++;
        end
        eng_en = 1'b1;
    endtask

    task automatic test_range();
        int s0;
        clear_q();
        s0 = start_cnt;
        send_cmd(5'd7, 5'd3);
        checks++;
        if (err_range !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || err_timeout !== 1'b0) begin
            $display("FAIL range_pulse: err_range=%b busy=%b cmd_ready=%b err_timeout=%b, required 1 0 1 0",
                     err_range, busy, cmd_ready, err_timeout);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (err_range !== 1'b0) begin
            $display("FAIL range_oneshot: err_range=%b second cycle, required 0", err_range);
            errors++;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (start_cnt != s0 || q_idx.size() != 0 || cmd_ready !== 1'b1) begin
            $display("FAIL range_quiet: starts=%0d results=%0d cmd_ready=%b, required 0 0 1",
                     start_cnt - s0, q_idx.size(), cmd_ready);
            errors++;
        end
    endtask

    task automatic test_done_wins();
        // done lands on the last WAIT cycle, the same cycle the timer expires
        eng_delay = TIMEOUT;
        clear_q();
        send_cmd(5'd6, 5'd6);
        wait_idle("donewins");
        checks++;
        if (q_idx.size() != 1 || q_data[0] !== 32'd8 || q_idx[0] !== 5'd6 || q_last[0] !== 1'b1 ||
            err_timeout !== 1'b0) begin
            $display("FAIL donewins_result: count=%0d data=%0d idx=%0d last=%b err_timeout=%b, required 1 8 6 1 0",
                     q_idx.size(), q_data[0], q_idx[0], q_last[0], err_timeout);
            errors++;
        end
        eng_delay = 3;
    endtask

    task automatic test_reset_midjob();
        int s1;
        eng_delay = 10;
        clear_q();
        send_cmd(5'd2, 5'd8);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || fib_i !== 5'd2) begin
            $display("FAIL midrst_pre: busy=%b fib_i=%0d, required 1 2", busy, fib_i);
            errors++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || fib_i !== '0 || fib_start !== 1'b0 || res_valid !== 1'b0) begin
            $display("FAIL midrst_async: busy=%b cmd_ready=%b fib_i=%0d fib_start=%b res_valid=%b, required 0 1 0 0 0",
                     busy, cmd_ready, fib_i, fib_start, res_valid);
            errors++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s1 = start_cnt;
        repeat (15) @(negedge clk);
        checks++;
        if (start_cnt != s1 || q_idx.size() != 0 || busy !== 1'b0) begin
            $display("FAIL midrst_quiet: starts=%0d results=%0d busy=%b, required 0 0 0",
                     start_cnt - s1, q_idx.size(), busy);
            errors++;
        end
        eng_delay = 2;
        send_cmd(5'd3, 5'd4);
        wait_idle("midrst");
        checks++;
        if (q_idx.size() != 2 || q_data[0] !== 32'd2 || q_last[0] !== 1'b0 ||
            q_data[1] !== 32'd3 || q_idx[1] !== 5'd4 || q_last[1] !== 1'b1) begin
            $display("FAIL midrst_rerun: count=%0d data0=%0d last0=%b data1=%0d idx1=%0d, required 2 2 0 3 4",
                     q_idx.size(), q_data[0], q_last[0], q_data[1], q_idx[1]);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_max_index();
        test_timeout();
        test_range();
        test_done_wins();
        test_reset_midjob();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
